// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on operand magnitudes, fixed 33-cycle latency.
module ex_muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            KILL,
   input  logic [2:0]      OP,
   input  logic [XLEN-1:0] OPERAND1,
   input  logic [XLEN-1:0] OPERAND2,
   input  logic [4:0]      REG_WRITE_ADDR,
   output logic [XLEN-1:0] RESULT,
   output logic [4:0]      RESULT_REG_WRITE_ADDR,
   output logic            DONE,
   output logic            BUSY
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

   state_t state, next_state;

   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic [4:0]        addr_q;
   logic [XLEN-1:0]   a;
   logic [XLEN-1:0]   b;
   logic [2*XLEN-1:0] acc;
   logic [XLEN:0]     rem;
   logic              prod_neg;
   logic              quo_neg;
   logic              rem_neg;

   logic              signed1;
   logic              signed2;
   logic              neg1;
   logic              neg2;
   logic [XLEN-1:0]   mag1;
   logic [XLEN-1:0]   mag2;
   logic              launch;
   logic              last_iter;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;
   logic [XLEN+1:0]   div_diff;
   logic              div_ge;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   result_sel;
   logic              unused_rem_msb;

   assign BUSY      = (state != IDLE);
   assign launch    = (state == IDLE) && START && !KILL;
   assign last_iter = (cnt == CW'(ITER - 1));

   // Only MULH/MULHSU/DIV/REM read rs1 as signed; MULHSU keeps rs2 unsigned.
   assign signed1 = (OP == 3'd1) || (OP == 3'd2) || (OP == 3'd4) || (OP == 3'd6);
   assign signed2 = (OP == 3'd1) || (OP == 3'd4) || (OP == 3'd6);
   assign neg1    = signed1 && OPERAND1[XLEN-1];
   assign neg2    = signed2 && OPERAND2[XLEN-1];
   assign mag1    = neg1 ? -OPERAND1 : OPERAND1;
   assign mag2    = neg2 ? -OPERAND2 : OPERAND2;

   // Multiply keeps the multiplicand in a and shifts the multiplier out of b;
   // divide shifts the dividend out of a against the divisor held in b.
   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (b[0] ? {1'b0, a} : '0);
   assign div_trial = {rem[XLEN-1:0], a[XLEN-1]};
   assign div_diff  = {1'b0, div_trial} - {2'b00, b};
   assign div_ge    = ~div_diff[XLEN+1];

   assign prod_fix = prod_neg ? -acc : acc;
   assign quo_fix  = quo_neg ? -a : a;
   assign rem_fix  = rem_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];

   // A partial remainder below the divisor never reaches the top bit.
   assign unused_rem_msb = rem[XLEN];

   always_comb begin
      result_sel = '0;
      case (op_q)
         3'd0:                   result_sel = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:       result_sel = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:             result_sel = quo_fix;
         default:                result_sel = rem_fix;
      endcase
   end

   // State register; reset outranks everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a flush returns to IDLE from any state.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (START) next_state = CALC;
         CALC:    if (last_iter) next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (KILL) next_state = IDLE;
   end

   // Datapath: capture on launch, one iteration per CALC cycle, commit in FIN.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         RESULT                <= '0;
         RESULT_REG_WRITE_ADDR <= '0;
         DONE                  <= 1'b0;
         cnt                   <= '0;
         op_q                  <= '0;
         addr_q                <= '0;
         a                     <= '0;
         b                     <= '0;
         acc                   <= '0;
         rem                   <= '0;
         prod_neg              <= 1'b0;
         quo_neg               <= 1'b0;
         rem_neg               <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  op_q     <= OP;
                  addr_q   <= REG_WRITE_ADDR;
                  a        <= mag1;
                  b        <= mag2;
                  acc      <= '0;
                  rem      <= '0;
                  cnt      <= '0;
                  prod_neg <= neg1 ^ neg2;
                  quo_neg  <= (neg1 ^ neg2) && (OPERAND2 != '0);
                  rem_neg  <= neg1;
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (op_q[2]) begin
                  a   <= {a[XLEN-2:0], div_ge};
                  rem <= div_ge ? div_diff[XLEN:0] : div_trial;
               end else begin
                  acc <= {mul_sum, acc[XLEN-1:1]};
                  b   <= {1'b0, b[XLEN-1:1]};
               end
            end
            FIN: begin
               if (!KILL) begin
                  RESULT                <= result_sel;
                  RESULT_REG_WRITE_ADDR <= addr_q;
                  DONE                  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
// Expected values are hand-computed RV32M results; latency and control behaviour are checked alongside.
module tb_ex_muldiv_unit;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic        KILL;
   logic [2:0]  OP;
   logic [31:0] OPERAND1;
   logic [31:0] OPERAND2;
   logic [4:0]  REG_WRITE_ADDR;
   logic [31:0] RESULT;
   logic [4:0]  RESULT_REG_WRITE_ADDR;
   logic        DONE;
   logic        BUSY;

   int compared   = 0;
   int mismatched = 0;
   int busyCycles = 0;

   ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
      .CLK                   (CLK),
      .RESET                 (RESET),
      .START                 (START),
      .KILL                  (KILL),
      .OP                    (OP),
      .OPERAND1              (OPERAND1),
      .OPERAND2              (OPERAND2),
      .REG_WRITE_ADDR        (REG_WRITE_ADDR),
      .RESULT                (RESULT),
      .RESULT_REG_WRITE_ADDR (RESULT_REG_WRITE_ADDR),
      .DONE                  (DONE),
      .BUSY                  (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one launch request at the falling edge; return 1 time unit after the sampling edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] addr, input logic start, input logic kill);
      @(negedge CLK);
      OP             = op;
      OPERAND1       = a;
      OPERAND2       = b;
      REG_WRITE_ADDR = addr;
      START          = start;
      KILL           = kill;
      @(posedge CLK);
      #1;
      START = 1'b0;
      KILL  = 1'b0;
   endtask

   // Launch an op and wait (bounded) for DONE; pokeAt >= 0 pulses a stray START mid-flight.
   task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input logic [31:0] expected, input int pokeAt);
      int cycles;
      applyStimulus(op, a, b, addr, 1'b1, 1'b0);
      cycles     = 0;
      busyCycles = 0;
      while (DONE !== 1'b1 && cycles < 50) begin
         if (BUSY === 1'b1) busyCycles++;
         if (cycles == pokeAt) begin
            START          = 1'b1;
            OP             = 3'd5;
            OPERAND1       = 32'h0000_0000;
            REG_WRITE_ADDR = 5'd31;
         end else begin
            START = 1'b0;
         end
         @(posedge CLK);
         #1;
         cycles++;
      end
      START = 1'b0;
      checkOutput({tag, "_latency"}, 32'(cycles), 32'd33);
      checkOutput({tag, "_result"}, RESULT, expected);
      checkOutput({tag, "_addr"}, {27'd0, RESULT_REG_WRITE_ADDR}, {27'd0, addr});
   endtask

   initial begin
      logic doneSeen;
      RESET          = 1'b1;
      START          = 1'b0;
      KILL           = 1'b0;
      OP             = 3'd0;
      OPERAND1       = 32'd0;
      OPERAND2       = 32'd0;
      REG_WRITE_ADDR = 5'd0;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset_result", RESULT, 32'd0);
      checkOutput("reset_addr", {27'd0, RESULT_REG_WRITE_ADDR}, 32'd0);
      checkOutput("reset_done", {31'd0, DONE}, 32'd0);
      checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      // MUL 7 * -3, with BUSY held for exactly 33 cycles and a one-cycle DONE.
      runOp("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, -1);
      checkOutput("mul_busy_cycles", 32'(busyCycles), 32'd33);
      checkOutput("mul_busy_in_done", {31'd0, BUSY}, 32'd0);
      @(posedge CLK);
      #1;
      checkOutput("mul_done_width", {31'd0, DONE}, 32'd0);

      // Back-to-back launches: each new START lands in the previous op's DONE cycle.
      runOp("mulh",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, -1);
      runOp("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000, -1);
      runOp("mulhu",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h7FFF_FFFF, -1);
      runOp("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, -1);
      runOp("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, -1);
      runOp("divu",   3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        -1);
      runOp("remu",   3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         -1);
      runOp("div0",   3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, -1);
      runOp("rem0",   3'd6, 32'd5,         32'd0,         5'd10, 32'd5,         -1);
      runOp("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, -1);
      runOp("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         -1);

      // A stray START while busy must neither relaunch nor disturb the op in flight.
      runOp("mul_poke", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFEB, 5);

      // Flush a DIV in its tenth cycle; RESULT keeps the MUL value above.
      applyStimulus(3'd4, 32'd100, 32'd7, 5'd14, 1'b1, 1'b0);
      repeat (9) begin
         @(posedge CLK);
         #1;
      end
      applyStimulus(3'd4, 32'd100, 32'd7, 5'd14, 1'b0, 1'b1);
      checkOutput("kill_busy", {31'd0, BUSY}, 32'd0);
      doneSeen = 1'b0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (DONE === 1'b1) doneSeen = 1'b1;
      end
      checkOutput("kill_no_done", {31'd0, doneSeen}, 32'd0);
      checkOutput("kill_result_held", RESULT, 32'hFFFF_FFEB);

      // START and KILL together in IDLE: nothing launches.
      applyStimulus(3'd5, 32'd100, 32'd7, 5'd15, 1'b1, 1'b1);
      checkOutput("startkill_busy", {31'd0, BUSY}, 32'd0);
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      checkOutput("startkill_busy_later", {31'd0, BUSY}, 32'd0);

      // Synchronous reset in the middle of CALC clears every output.
      applyStimulus(3'd5, 32'd100, 32'd7, 5'd16, 1'b1, 1'b0);
      repeat (5) begin
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("midreset_result", RESULT, 32'd0);
      checkOutput("midreset_addr", {27'd0, RESULT_REG_WRITE_ADDR}, 32'd0);
      checkOutput("midreset_done", {31'd0, DONE}, 32'd0);
      checkOutput("midreset_busy", {31'd0, BUSY}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      runOp("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE, -1);
      runOp("divu0",     3'd5, 32'd7,         32'd0,         5'd18, 32'hFFFF_FFFF, -1);
      runOp("remneg0",   3'd6, 32'hFFFF_FFFB, 32'd0,         5'd19, 32'hFFFF_FFFB, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
